// File: rtl/alu_serial_core_p.sv
// Serial ALU core: receives B/A operand bytes and a command packet on sin,
// validates the frame and returns a result or error frame on sout.
module alu_serial_core_p #(
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout,
  output logic busy
);
  localparam int unsigned W     = 8 * DATA_BYTES;
  localparam int unsigned NB    = 2 * DATA_BYTES;
  localparam int unsigned CNT_W = $clog2(NB + 2);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned BI_W  = (DATA_BYTES < 2) ? 1 : $clog2(DATA_BYTES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NB);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NB + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_SEND_DATA, TX_SEND_STATUS, TX_SEND_ERR} tx_state_e;

  rx_state_e        rx_state_q;
  logic [9:0]       rx_sh_q;
  logic [3:0]       rx_bit_q;
  logic [2*W-1:0]   buf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             frame_err_q;
  logic             armed_q;
  logic [TO_W-1:0]  to_cnt_q;

  tx_state_e        tx_state_q;
  logic             sout_q;
  logic             busy_q;
  logic [W-1:0]     c_q;
  logic [3:0]       flags_q;
  logic [2:0]       err_q;
  logic [9:0]       tx_sh_q;
  logic [3:0]       tx_bit_q;
  logic [BI_W-1:0]  byte_idx_q;

  function automatic logic [3:0] crc4_f(input logic [2*W+3:0] msg);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 2*W+4; i++) begin
      fb = c[3] ^ msg[2*W+3-i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3_f(input logic [W+4:0] msg);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < W+5; i++) begin
      fb = c[2] ^ msg[W+4-i];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

  logic [W-1:0] b_w, a_w, alu_c;
  logic [W:0]   sum_w, diff_w;
  logic [2:0]   op_w;
  logic [3:0]   alu_flags;
  logic         carry_w, ovf_w, cmd_fire, err_data, err_crc, err_op;

  always_comb begin
    b_w      = buf_q[2*W-1:W];
    a_w      = buf_q[W-1:0];
    op_w     = rx_sh_q[7:5];
    cmd_fire = (rx_state_q == RX_CHECK) && rx_sh_q[9];
    err_data = frame_err_q || !rx_sh_q[0] || (cnt_q != CNT_FULL);
    err_crc  = !err_data && (rx_sh_q[4:1] != crc4_f({b_w, a_w, 1'b1, op_w}));
    err_op   = !err_data && !err_crc &&
               !(op_w == 3'b000 || op_w == 3'b001 || op_w == 3'b100 || op_w == 3'b101);
    sum_w    = {1'b0, b_w} + {1'b0, a_w};
    diff_w   = {1'b0, b_w} - {1'b0, a_w};
    alu_c    = '0;
    carry_w  = 1'b0;
    ovf_w    = 1'b0;
    case (op_w)
      3'b000: alu_c = b_w & a_w;
      3'b001: alu_c = b_w | a_w;
      3'b100: begin
        alu_c   = sum_w[W-1:0];
        carry_w = sum_w[W];
        ovf_w   = (b_w[W-1] == a_w[W-1]) && (alu_c[W-1] != b_w[W-1]);
      end
      3'b101: begin
        // Extra MSB of the widened difference is the unsigned borrow.
        alu_c   = diff_w[W-1:0];
        carry_w = diff_w[W];
        ovf_w   = (b_w[W-1] != a_w[W-1]) && (alu_c[W-1] != b_w[W-1]);
      end
      default: ;
    endcase
    alu_flags = {carry_w, ovf_w, (alu_c == '0), alu_c[W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_sh_q     <= '0;
      rx_bit_q    <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      to_cnt_q <= '0;
      if (busy_q) begin
        rx_state_q <= RX_IDLE;
        armed_q    <= 1'b0;
      end else begin
        case (rx_state_q)
          RX_IDLE: begin
            if (!armed_q) begin
              armed_q <= sin;
            end else if (!sin) begin
              rx_state_q <= RX_SHIFT;
              rx_bit_q   <= '0;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q != '0) begin
              if (to_cnt_q == TO_LAST) begin
                buf_q       <= '0;
                cnt_q       <= '0;
                frame_err_q <= 1'b0;
              end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
              end
            end
          end
          RX_SHIFT: begin
            rx_sh_q  <= {rx_sh_q[8:0], sin};
            rx_bit_q <= rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd9) rx_state_q <= RX_CHECK;
          end
          RX_CHECK: begin
            if (rx_sh_q[9]) begin
              buf_q       <= '0;
              cnt_q       <= '0;
              frame_err_q <= 1'b0;
              armed_q     <= 1'b0;
              rx_state_q  <= RX_IDLE;
            end else begin
              buf_q <= {buf_q[2*W-9:0], rx_sh_q[8:1]};
              if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
              if (!rx_sh_q[0]) frame_err_q <= 1'b1;
              // A start bit right after a data stop bit begins the next packet.
              if (!sin) begin
                rx_state_q <= RX_SHIFT;
                rx_bit_q   <= '0;
              end else begin
                rx_state_q <= RX_IDLE;
              end
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  logic [2:0]      crc3_w;
  logic [BI_W-1:0] nxt_idx;
  logic [7:0]      next_byte;
  logic [9:0]      err_pkt, status_pkt;

  always_comb begin
    crc3_w     = crc3_f({c_q, 1'b0, flags_q});
    nxt_idx    = byte_idx_q - BI_W'(1);
    next_byte  = c_q[{nxt_idx, 3'b000} +: 8];
    err_pkt    = {2'b11, err_q, err_q, ^{1'b1, err_q, err_q}, 1'b1};
    status_pkt = {2'b10, flags_q, crc3_w, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      sout_q     <= 1'b1;
      busy_q     <= 1'b0;
      c_q        <= '0;
      flags_q    <= '0;
      err_q      <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      byte_idx_q <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          sout_q <= 1'b1;
          if (cmd_fire) begin
            busy_q     <= 1'b1;
            c_q        <= alu_c;
            flags_q    <= alu_flags;
            err_q      <= {err_data, err_crc, err_op};
            tx_state_q <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          sout_q   <= 1'b0;
          tx_bit_q <= '0;
          if (err_q != '0) begin
            tx_sh_q    <= err_pkt;
            tx_state_q <= TX_SEND_ERR;
          end else begin
            tx_sh_q    <= {1'b0, c_q[W-1 -: 8], 1'b1};
            byte_idx_q <= BI_W'(DATA_BYTES - 1);
            tx_state_q <= TX_SEND_DATA;
          end
        end
        default: begin
          if (tx_bit_q != 4'd10) begin
            sout_q   <= tx_sh_q[9];
            tx_sh_q  <= {tx_sh_q[8:0], 1'b0};
            tx_bit_q <= tx_bit_q + 4'd1;
          end else if (tx_state_q == TX_SEND_DATA) begin
            sout_q   <= 1'b0;
            tx_bit_q <= '0;
            if (byte_idx_q != '0) begin
              tx_sh_q    <= {1'b0, next_byte, 1'b1};
              byte_idx_q <= nxt_idx;
            end else begin
              tx_sh_q    <= status_pkt;
              tx_state_q <= TX_SEND_STATUS;
            end
          end else begin
            sout_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_alu_serial_core_p.sv
// Directed bench for alu_serial_core_p with 4-byte and 2-byte instances.
module tb_alu_serial_core_p;
  logic clk = 1'b0;
  logic rst_n;
  logic sin4, sin2;
  logic sout4, busy4, sout2, busy2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_serial_core_p #(.DATA_BYTES(4), .TIMEOUT_CYCLES(64)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sin(sin4), .sout(sout4), .busy(busy4));
  alu_serial_core_p #(.DATA_BYTES(2), .TIMEOUT_CYCLES(64)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sin(sin2), .sout(sout2), .busy(busy2));

  typedef struct {
    int          db;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    bit          crc_bad;
    int          ndata;
    bit          exp_err;
    logic [31:0] exp_c;
    logic [3:0]  exp_flags;
    logic [5:0]  exp_eb;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic get_sout(input int db);
    return (db == 4) ? sout4 : sout2;
  endfunction

  function automatic logic get_busy(input int db);
    return (db == 4) ? busy4 : busy2;
  endfunction

  // Reference CRCs by polynomial long division of msg * x^n.
  function automatic logic [3:0] ref_crc4(input int db, input logic [31:0] b,
                                          input logic [31:0] a, input logic [2:0] op);
    logic [99:0] m;
    int          len;
    len = 16*db + 4;
    m = ({68'b0, b} << (8*db)) | {68'b0, a};
    m = (m << 4) | {96'b0, 1'b1, op};
    m = m << 4;
    for (int i = len + 3; i >= 4; i--)
      if (m[i]) m = m ^ ({95'b0, 5'b10011} << (i - 4));
    return m[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input int db, input logic [31:0] c, input logic [3:0] fl);
    logic [63:0] m;
    int          len;
    len = 8*db + 5;
    m = {32'b0, c};
    m = (m << 5) | {59'b0, 1'b0, fl};
    m = m << 3;
    for (int i = len + 2; i >= 3; i--)
      if (m[i]) m = m ^ ({60'b0, 4'b1011} << (i - 3));
    return m[2:0];
  endfunction

  task automatic drive_bit(input int db, input logic b);
    if (db == 4) sin4 = b; else sin2 = b;
    @(negedge clk);
  endtask

  task automatic send_packet(input int db, input logic typ, input logic [7:0] pl);
    logic [10:0] p;
    p = {1'b0, typ, pl, 1'b1};
    for (int i = 10; i >= 0; i--) drive_bit(db, p[i]);
  endtask

  task automatic send_frame(input vec_t v);
    logic [63:0] full;
    logic [3:0]  crc;
    int          idx;
    full = ({32'b0, v.b} << (8*v.db)) | {32'b0, v.a};
    for (int i = 0; i < v.ndata; i++) begin
      idx = 2*v.db - 1 - i;
      if (idx >= 0) send_packet(v.db, 1'b0, full[8*idx +: 8]);
      else          send_packet(v.db, 1'b0, 8'hA5);
    end
    crc = ref_crc4(v.db, v.b, v.a, v.op) ^ {3'b000, v.crc_bad};
    send_packet(v.db, 1'b1, {1'b0, v.op, crc});
  endtask

  task automatic recv_check(input vec_t v, input string nm);
    int          k;
    int          npk;
    logic [10:0] got;
    logic [10:0] exp;
    logic [2:0]  c3;
    k = 0;
    while (get_sout(v.db) !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, 32'(k), 32'd2);
    chk({nm, " busy high"}, {31'b0, get_busy(v.db)}, 32'd1);
    npk = v.exp_err ? 1 : v.db + 1;
    c3  = ref_crc3(v.db, v.exp_c, v.exp_flags);
    for (int p = 0; p < npk; p++) begin
      for (int j = 10; j >= 0; j--) begin
        got[j] = get_sout(v.db);
        @(negedge clk);
      end
      if (v.exp_err)     exp = {3'b011, v.exp_eb, ^{1'b1, v.exp_eb}, 1'b1};
      else if (p < v.db) exp = {2'b00, v.exp_c[8*(v.db-1-p) +: 8], 1'b1};
      else               exp = {3'b010, v.exp_flags, c3, 1'b1};
      chk($sformatf("%s pkt%0d", nm, p), {21'b0, got}, {21'b0, exp});
    end
    chk({nm, " busy low"}, {31'b0, get_busy(v.db)}, 32'd0);
    chk({nm, " sout idle"}, {31'b0, get_sout(v.db)}, 32'd1);
  endtask

  initial begin
    int k;
    bit quiet;
    rst_n = 1'b0;
    sin4  = 1'b1;
    sin2  = 1'b1;

    //          db  a             b             op      bad ndata err c             flags    eb
    vecs[0]  = '{4, 32'h00000003, 32'h00000005, 3'b100, 0,  8,    0,  32'h00000008, 4'b0000, 6'b000000};
    vecs[1]  = '{4, 32'hFFFFFFFF, 32'h00000001, 3'b100, 0,  8,    0,  32'h00000000, 4'b1010, 6'b000000};
    vecs[2]  = '{4, 32'h00000003, 32'h00000005, 3'b101, 0,  8,    0,  32'h00000002, 4'b0000, 6'b000000};
    vecs[3]  = '{4, 32'h0F0F00FF, 32'hFF00F0F0, 3'b000, 0,  8,    0,  32'h0F0000F0, 4'b0000, 6'b000000};
    vecs[4]  = '{4, 32'h00000001, 32'h80000000, 3'b001, 0,  8,    0,  32'h80000001, 4'b0001, 6'b000000};
    vecs[5]  = '{4, 32'h00000005, 32'h00000003, 3'b101, 0,  8,    0,  32'hFFFFFFFE, 4'b1001, 6'b000000};
    vecs[6]  = '{4, 32'h00000001, 32'h80000000, 3'b101, 0,  8,    0,  32'h7FFFFFFF, 4'b0100, 6'b000000};
    vecs[7]  = '{4, 32'h00000003, 32'h00000005, 3'b100, 1,  8,    1,  32'h0,        4'b0000, 6'b010010};
    vecs[8]  = '{4, 32'h00000003, 32'h00000005, 3'b100, 0,  7,    1,  32'h0,        4'b0000, 6'b100100};
    vecs[9]  = '{4, 32'h00000003, 32'h00000005, 3'b010, 0,  8,    1,  32'h0,        4'b0000, 6'b001001};
    vecs[10] = '{4, 32'h00000003, 32'h00000005, 3'b100, 0,  0,    1,  32'h0,        4'b0000, 6'b100100};
    vecs[11] = '{2, 32'h00008000, 32'h00008000, 3'b100, 0,  4,    0,  32'h00000000, 4'b1110, 6'b000000};
    vecs[12] = '{2, 32'h00000001, 32'h00000000, 3'b101, 0,  4,    0,  32'h0000FFFF, 4'b1001, 6'b000000};

    repeat (3) @(negedge clk);
    chk("reset sout4", {31'b0, sout4}, 32'd1);
    chk("reset busy4", {31'b0, busy4}, 32'd0);
    chk("reset sout2", {31'b0, sout2}, 32'd1);
    chk("reset busy2", {31'b0, busy2}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i]);
      recv_check(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Partial frame abandoned for longer than the timeout, then a full frame.
    for (int i = 0; i < 3; i++) send_packet(4, 1'b0, 8'(8'h11 * (i + 1)));
    quiet = 1'b1;
    repeat (70) begin
      if (sout4 !== 1'b1 || busy4 !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk("timeout no response", {31'b0, quiet}, 32'd1);
    send_frame(vecs[0]);
    recv_check(vecs[0], "after timeout");
    repeat (2) @(negedge clk);

    // Reset asserted while the response start bit is on the line.
    send_frame(vecs[1]);
    k = 0;
    while (sout4 !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("midreset start seen", {31'b0, sout4}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset sout", {31'b0, sout4}, 32'd1);
    chk("midreset busy", {31'b0, busy4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(vecs[2]);
    recv_check(vecs[2], "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
